// File: rtl/instruction_fetch.sv
// Instruction fetch stage: streams a run of consecutive imem words into a small
// first-word-fall-through FIFO and hands them to the decoder over valid/ready.
//
// Handshake: a word is transferred on every rising edge where inst_valid and
// inst_ready are both high; inst_data is held steady while inst_valid is high
// and inst_ready is low, and inst_valid never drops without a transfer (except
// on reset).
module instruction_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [COUNT_W-1:0]    num_inst,
    output logic                  busy,
    output logic                  done,
    output logic                  imem_read_req,
    output logic [ADDR_WIDTH-1:0] imem_read_addr,
    input  logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  inst_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [COUNT_W-1:0]    num_q, num_d;
    logic [COUNT_W-1:0]    issued_q, issued_d;
    logic [COUNT_W-1:0]    returned_q, returned_d;
    logic                  pend_q, pend_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic credit_ok;

    // Credit check uses registered occupancy plus the word in flight only, so a
    // same-cycle pop never lets a request through and the FIFO cannot overflow.
    assign credit_ok      = (fifo_count_q + CNT_W'(pend_q)) < CNT_W'(FIFO_DEPTH);
    assign imem_read_req  = (state_q == S_FETCH) && credit_ok;
    assign imem_read_addr = addr_q;

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign inst_valid = (fifo_count_q != '0);
    assign inst_data  = inst_valid ? mem_q[rd_ptr_q] : '0;

    // imem data is valid exactly one cycle after the request.
    assign push = pend_q;
    assign pop  = inst_valid && inst_ready;

    // Next-state logic for the run FSM, address/count tracking and FIFO pointers.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        num_d        = num_q;
        issued_d     = issued_q;
        returned_d   = returned_q;
        pend_d       = imem_read_req;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);

        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            returned_d = returned_q + COUNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_inst != '0) begin
                        state_d    = S_FETCH;
                        addr_d     = start_addr;
                        num_d      = num_inst;
                        issued_d   = '0;
                        returned_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (imem_read_req) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + COUNT_W'(1);
                    if (issued_q + COUNT_W'(1) == num_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((returned_q == num_q) && !pend_q && (fifo_count_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state; reset discards buffered words and the word in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            num_q        <= '0;
            issued_q     <= '0;
            returned_q   <= '0;
            pend_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            num_q        <= num_d;
            issued_q     <= issued_d;
            returned_q   <= returned_d;
            pend_q       <= pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= imem_read_data;
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage between the instruction memory read port and the instruction decoder. On a `start` pulse it streams `num_inst` consecutive words from imem, starting at `start_addr`. It absorbs imem's one-cycle registered read latency and buffers words in a small first-word-fall-through FIFO. Words go to the decoder over a valid/ready handshake, and `done` pulses when the last word has been consumed.

## Interface
- `DATA_WIDTH`, 32, instruction word width; equals the imem data width.
- `ADDR_WIDTH`, 11, imem word-address width.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.
- `COUNT_W`, 16, width of the instruction-count input and internal counters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `start`  in  1  one-cycle pulse that begins a fetch run; ignored while `busy`.
- `start_addr`  in  ADDR_WIDTH  first imem word address; sampled on `start`.
- `num_inst`  in  COUNT_W  number of words to fetch; sampled on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse at run completion.
- `imem_read_req`  out  1  imem read request.
- `imem_read_addr`  out  ADDR_WIDTH  imem read address.
- `imem_read_data`  in  DATA_WIDTH  imem read data, valid the cycle after `imem_read_req`.
- `inst_valid`  out  1  FIFO non-empty.
- `inst_data`  out  DATA_WIDTH  FIFO head word.
- `inst_ready`  in  1  decoder accepts `inst_data` when high with `inst_valid`.

## Operation
- **FSM states:** IDLE, FETCH, DRAIN, DONE.
- **IDLE:**
  - `start`=1 with `num_inst`≠0 → FETCH. Latch the address into `addr_q`, latch the count, clear `issued_q` and `returned_q`.
  - `start`=1 with `num_inst`=0 → DONE. No reads are issued.
- **FETCH:**
  - `imem_read_req` = (`fifo_count_q` + `pend_q` < FIFO_DEPTH). Registered values only; a pop in the same cycle earns no credit.
  - `imem_read_addr` = `addr_q`.
  - Each request increments `addr_q` modulo 2^ADDR_WIDTH and increments `issued_q`.
  - Leave for DRAIN on the edge where `issued_q` reaches `num_inst`.
- **`pend_q` tracking:** `pend_q` <= `imem_read_req`. When `pend_q`=1, `imem_read_data` is pushed into the FIFO and `returned_q` increments. Data is captured only in that cycle.
- **DRAIN:** no requests. Go to DONE when `returned_q`==`num_inst`, `pend_q`=0, and the FIFO is empty. The FIFO counts as empty in the cycle after the last pop.
- **DONE:** one cycle with `done`=1, then IDLE.
- **FIFO:** first-word-fall-through.
  - Pop = `inst_valid` & `inst_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - Overflow cannot occur because of the credit rule.
  - `inst_data` holds steady while `inst_valid` & !`inst_ready`.
- **`start` while `busy`:** ignored; no effect on the latched address or count.
- **Reset (`reset`=0), including mid-run:**
  - State → IDLE; all counters, `pend_q`, and FIFO pointers clear.
  - Buffered words are discarded; the imem word in flight is dropped.
- **Width rules:**
  - `issued_q` and `returned_q` are COUNT_W bits.
  - `fifo_count_q` is $clog2(FIFO_DEPTH)+1 bits.
  - Address arithmetic wraps (2^ADDR_WIDTH−1 → 0).

## Timing
- **Reset values:** `busy`=0, `done`=0, `imem_read_req`=0, `imem_read_addr`=0, `inst_valid`=0, `inst_data`=0.
- **Startup latency** (`start` sampled at the end of cycle 0):
  - FETCH and first request in cycle 1.
  - FIFO push at the end of cycle 2.
  - `inst_valid` in cycle 3.
- **Throughput:** one word per cycle with `inst_ready` held high.
- **Outputs:** `busy`, `done`, and `inst_valid` come from registered state. `imem_read_req` and `imem_read_addr` are combinational from registered state only, with no input-to-output path.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `start`=1 → all outputs 0, no `imem_read_req`.
- **Basic run:** `start_addr`=0x010, `num_inst`=5, `inst_ready`=1, imem returns address as data →
  - requests in cycles 1–5 at 0x010–0x014;
  - `inst_valid` in cycles 3–7 with data 0x010–0x014 in order;
  - `done` in cycle 9, `busy` in cycles 1–9.
- **Backpressure:** `num_inst`=8, `inst_ready`=0 →
  - exactly 4 requests (0x000–0x003), then `imem_read_req` stays 0;
  - `inst_data`=0x000 stable;
  - after raising `inst_ready`, all 8 words arrive in order, none duplicated or lost.
- **Wrap and zero count:**
  - `start_addr`=2047, `num_inst`=3 → addresses 2047, 0, 1.
  - `num_inst`=0 → no requests, `done` in cycle 1.
- **Mid-run reset and ignored start:**
  - Assert `reset`=0 after 2 words delivered → `inst_valid`=0 next cycle. A new run then starts clean from its own `start_addr`.
  - A `start` pulsed while `busy` changes nothing.
